// File: rtl/axi_lite_to_dm_slave_if.sv
// AXI-Lite bus bundle between the SoC interconnect and the debug-module bridge.
//   master : interconnect side (drives AW/W/AR channels and B/R ready)
//   slave  : bridge side (drives AW/W/AR ready and B/R responses)
interface axi_lite_to_dm_slave_if;
  logic [31:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready,
           s_rdata, s_rresp, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready,
           s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/axi_lite_to_dm_slave.sv
// AXI-Lite slave bridge into the debug module's fixed-latency slave port.
// Each AXI-Lite read or write becomes a single-cycle req strobe on the dm_*
// side; the result is returned as an OKAY AXI-Lite response.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   s                AXI-Lite slave bus (axi_lite_to_dm_slave_if.slave)
//   dm_req_o/we_o    request strobe / write enable
//   dm_addr_o        word-aligned, DM_ADDR_MASK-masked address
//   dm_be_o/wdata_o  byte enables / write data
//   dm_rdata_i       read data, valid READ_LATENCY cycles after dm_req_o
//   state_o          current FSM state (debug)
module axi_lite_to_dm_slave #(
  parameter logic [31:0] DM_ADDR_MASK = 32'h0000_0FFF,
  parameter int unsigned READ_LATENCY = 1  // 1..4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  axi_lite_to_dm_slave_if.slave         s,
  output logic                          dm_req_o,
  output logic                          dm_we_o,
  output logic [31:0]                   dm_addr_o,
  output logic [3:0]                    dm_be_o,
  output logic [31:0]                   dm_wdata_o,
  input  logic [31:0]                   dm_rdata_i,
  output logic [2:0]                    state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_COLLECT = 3'd1,
    W_REQ     = 3'd2,
    W_RESP    = 3'd3,
    R_REQ     = 3'd4,
    R_WAIT    = 3'd5,
    R_RESP    = 3'd6
  } state_e;

  // Word alignment folded into the mask so every address bit is consumed.
  localparam logic [31:0] ADDR_KEEP = DM_ADDR_MASK & 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic        aw_got_q, aw_got_d;
  logic        w_got_q, w_got_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [3:0]  dm_be_q, dm_be_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;

  logic accept_w, aw_hs, w_hs, ar_hs, aw_now, w_now;

  // Readies are gated by rst_n so nothing is accepted while reset is held.
  assign accept_w    = rst_n && (state_q == IDLE || state_q == W_COLLECT);
  assign s.s_awready = accept_w && !aw_got_q;
  assign s.s_wready  = accept_w && !w_got_q;
  assign s.s_arready = rst_n && (state_q == IDLE) && !s.s_awvalid && !s.s_wvalid;

  assign aw_hs  = s.s_awvalid && s.s_awready;
  assign w_hs   = s.s_wvalid && s.s_wready;
  assign ar_hs  = s.s_arvalid && s.s_arready;
  assign aw_now = aw_got_q || aw_hs;
  assign w_now  = w_got_q || w_hs;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, W_COLLECT: begin
        if (aw_now && w_now)      state_d = W_REQ;
        else if (aw_now || w_now) state_d = W_COLLECT;
        else if (ar_hs)           state_d = R_REQ;
      end
      W_REQ:   state_d = W_RESP;
      W_RESP:  if (s.s_bready) state_d = IDLE;
      R_REQ:   state_d = R_WAIT;
      R_WAIT:  if (cnt_q == 2'd0) state_d = R_RESP;
      R_RESP:  if (s.s_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    dm_req_o   = 1'b0;
    dm_we_o    = 1'b0;
    s.s_bvalid = 1'b0;
    s.s_rvalid = 1'b0;
    case (state_q)
      W_REQ: begin
        dm_req_o = (wstrb_q != '0);
        dm_we_o  = 1'b1;
      end
      W_RESP:  s.s_bvalid = 1'b1;
      R_REQ:   dm_req_o   = 1'b1;
      R_RESP:  s.s_rvalid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: capture AW/W halves, load dm outputs on entry to a
  // request state so they are valid during the strobe and hold afterwards.
  always_comb begin
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    dm_addr_d  = dm_addr_q;
    dm_be_d    = dm_be_q;
    dm_wdata_d = dm_wdata_q;

    if (aw_hs) begin
      aw_got_d = 1'b1;
      awaddr_d = s.s_awaddr;
    end
    if (w_hs) begin
      w_got_d = 1'b1;
      wdata_d = s.s_wdata;
      wstrb_d = s.s_wstrb;
    end
    if (state_d == W_REQ && state_q != W_REQ) begin
      aw_got_d   = 1'b0;
      w_got_d    = 1'b0;
      dm_addr_d  = awaddr_d & ADDR_KEEP;
      dm_be_d    = wstrb_d;
      dm_wdata_d = wdata_d;
    end
    if (ar_hs) dm_addr_d = s.s_araddr & ADDR_KEEP;

    if (state_q == R_REQ) cnt_d = 2'(READ_LATENCY - 1);
    else if (state_q == R_WAIT && cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;

    if (state_q == R_WAIT && cnt_q == 2'd0) rdata_d = dm_rdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      dm_addr_q  <= '0;
      dm_be_q    <= '0;
      dm_wdata_q <= '0;
    end else begin
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      dm_addr_q  <= dm_addr_d;
      dm_be_q    <= dm_be_d;
      dm_wdata_q <= dm_wdata_d;
    end
  end

  assign s.s_bresp  = '0;
  assign s.s_rresp  = '0;
  assign s.s_rdata  = rdata_q;
  assign dm_addr_o  = dm_addr_q;
  assign dm_be_o    = dm_be_q;
  assign dm_wdata_o = dm_wdata_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_axi_lite_to_dm_slave.sv
module tb_axi_lite_to_dm_slave;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dm_req_o, dm_we_o;
  logic [31:0] dm_addr_o, dm_wdata_o;
  logic [31:0] dm_rdata_i = '0;
  logic [3:0]  dm_be_o;
  logic [2:0]  state_o;

  axi_lite_to_dm_slave_if bus();

  axi_lite_to_dm_slave #(.DM_ADDR_MASK(32'h0000_0FFF), .READ_LATENCY(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (bus),
    .dm_req_o   (dm_req_o),
    .dm_we_o    (dm_we_o),
    .dm_addr_o  (dm_addr_o),
    .dm_be_o    (dm_be_o),
    .dm_wdata_o (dm_wdata_o),
    .dm_rdata_i (dm_rdata_i),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] rd_q[$];
  logic [1:0]  b_q[$];
  req_t        e;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] rd_value = '0;
  logic        prev_req = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic we, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] d);
    req_t r;
    r.we = we; r.addr = a; r.be = be; r.wdata = d;
    req_q.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_b(output int n);
    n = 0;
    @(negedge clk);
    while (!bus.s_bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_r(output int n);
    n = 0;
    @(negedge clk);
    while (!bus.s_rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Debug-module model: one-cycle read latency; stale cycles return junk.
  always @(posedge clk)
    dm_rdata_i <= (dm_req_o && !dm_we_o) ? rd_value : 32'hBAD0_BAD0;

  // Scoreboard monitors
  always @(negedge clk) begin
    if (dm_req_o) begin
      check("req_not_back_to_back", 32'(prev_req), 0);
      if (req_q.size() == 0) check("req_queue_depth", 32'(req_q.size()), 1);
      else begin
        e = req_q.pop_front();
        check("req_we", 32'(dm_we_o), 32'(e.we));
        check("req_addr", dm_addr_o, e.addr);
        if (e.we) begin
          check("req_be", 32'(dm_be_o), 32'(e.be));
          check("req_wdata", dm_wdata_o, e.wdata);
        end
      end
    end
    prev_req = dm_req_o;
    if (bus.s_bvalid && bus.s_bready) begin
      if (b_q.size() == 0) check("b_queue_depth", 32'(b_q.size()), 1);
      else check("bresp", 32'(bus.s_bresp), 32'(b_q.pop_front()));
    end
    if (bus.s_rvalid && bus.s_rready) begin
      if (rd_q.size() == 0) check("r_queue_depth", 32'(rd_q.size()), 1);
      else begin
        check("rdata", bus.s_rdata, rd_q.pop_front());
        check("rresp", 32'(bus.s_rresp), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bus.s_awaddr = '0; bus.s_awvalid = 1'b0;
    bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wvalid = 1'b0;
    bus.s_bready = 1'b0;
    bus.s_araddr = '0; bus.s_arvalid = 1'b0; bus.s_rready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(state_o), 0);
    check("rst_awready", 32'(bus.s_awready), 0);
    check("rst_wready", 32'(bus.s_wready), 0);
    check("rst_arready", 32'(bus.s_arready), 0);
    check("rst_bvalid", 32'(bus.s_bvalid), 0);
    check("rst_rvalid", 32'(bus.s_rvalid), 0);
    check("rst_req", 32'(dm_req_o), 0);
    check("rst_rdata", bus.s_rdata, 0);
    check("rst_dm_addr", dm_addr_o, 0);
    rst_n = 1'b1;

    // 1: AW and W in the same cycle
    tick();
    bus.s_bready = 1'b1;
    push_req(1'b1, 32'h0000_0808, 4'hF, 32'hDEAD_BEEF);
    b_q.push_back(2'b00);
    bus.s_awaddr = 32'h0000_0808; bus.s_awvalid = 1'b1;
    bus.s_wdata = 32'hDEAD_BEEF; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
    @(negedge clk);
    check("t1_awready", 32'(bus.s_awready), 1);
    check("t1_wready", 32'(bus.s_wready), 1);
    check("t1_arready", 32'(bus.s_arready), 0);
    tick();
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    wait_b(n);
    check("t1_b_latency", n, 1);
    tick();
    @(negedge clk);
    check("t1_idle", 32'(state_o), 0);

    // 2: W first, AW (out of range) later
    tick();
    push_req(1'b1, 32'h0000_0804, 4'h3, 32'hCAFE_F00D);
    b_q.push_back(2'b00);
    bus.s_wdata = 32'hCAFE_F00D; bus.s_wstrb = 4'h3; bus.s_wvalid = 1'b1;
    @(negedge clk);
    check("t2_wready", 32'(bus.s_wready), 1);
    tick();
    bus.s_wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t2_collect_state", 32'(state_o), 1);
      check("t2_wready_low", 32'(bus.s_wready), 0);
      check("t2_awready_high", 32'(bus.s_awready), 1);
      tick();
    end
    bus.s_awaddr = 32'h0001_0804; bus.s_awvalid = 1'b1;
    @(negedge clk);
    check("t2_awready", 32'(bus.s_awready), 1);
    tick();
    bus.s_awvalid = 1'b0;
    wait_b(n);
    check("t2_b_latency", n, 1);
    tick();
    @(negedge clk);
    check("t2_idle", 32'(state_o), 0);

    // 3: read with rready held off
    tick();
    rd_value = 32'h1234_5678;
    push_req(1'b0, 32'h0000_0800, 4'h0, 32'h0);
    rd_q.push_back(32'h1234_5678);
    bus.s_rready = 1'b0;
    bus.s_araddr = 32'h0000_0800; bus.s_arvalid = 1'b1;
    @(negedge clk);
    check("t3_arready", 32'(bus.s_arready), 1);
    tick();
    bus.s_arvalid = 1'b0;
    wait_r(n);
    check("t3_r_latency", n, 2);
    for (int i = 0; i < 4; i++) begin
      check("t3_rvalid_hold", 32'(bus.s_rvalid), 1);
      check("t3_rdata_hold", bus.s_rdata, 32'h1234_5678);
      @(negedge clk);
    end
    tick();
    bus.s_rready = 1'b1;
    @(negedge clk);
    tick();
    bus.s_rready = 1'b0;
    @(negedge clk);
    check("t3_idle", 32'(state_o), 0);
    check("t3_rvalid_low", 32'(bus.s_rvalid), 0);

    // 4: AR together with AW/W; write wins
    tick();
    push_req(1'b1, 32'h0000_0010, 4'hF, 32'h1111_2222);
    b_q.push_back(2'b00);
    push_req(1'b0, 32'h0000_0C10, 4'h0, 32'h0);
    rd_q.push_back(32'hA5A5_5A5A);
    bus.s_awaddr = 32'h0000_0010; bus.s_awvalid = 1'b1;
    bus.s_wdata = 32'h1111_2222; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
    bus.s_araddr = 32'h0000_0C10; bus.s_arvalid = 1'b1;
    @(negedge clk);
    check("t4_arready_blocked", 32'(bus.s_arready), 0);
    check("t4_awready", 32'(bus.s_awready), 1);
    tick();
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    wait_b(n);
    check("t4_b_latency", n, 1);
    check("t4_arready_in_resp", 32'(bus.s_arready), 0);
    tick();
    @(negedge clk);
    check("t4_idle", 32'(state_o), 0);
    check("t4_arready_idle", 32'(bus.s_arready), 1);
    tick();
    bus.s_arvalid = 1'b0;
    rd_value = 32'hA5A5_5A5A;
    bus.s_rready = 1'b1;
    wait_r(n);
    check("t4_r_latency", n, 2);
    tick();
    bus.s_rready = 1'b0;

    // 5: zero strobes -> no request, still a response
    tick();
    b_q.push_back(2'b00);
    bus.s_awaddr = 32'h0000_0020; bus.s_awvalid = 1'b1;
    bus.s_wdata = 32'h0000_0055; bus.s_wstrb = 4'h0; bus.s_wvalid = 1'b1;
    @(negedge clk);
    check("t5_awready", 32'(bus.s_awready), 1);
    tick();
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    wait_b(n);
    check("t5_b_latency", n, 1);
    tick();
    @(negedge clk);
    check("t5_idle", 32'(state_o), 0);
    check("t5_no_req_pending", 32'(req_q.size()), 0);

    // 6: reset during R_WAIT
    tick();
    push_req(1'b0, 32'h0000_0900, 4'h0, 32'h0);
    rd_value = 32'h0BAD_0BAD;
    bus.s_araddr = 32'h0000_0900; bus.s_arvalid = 1'b1;
    @(negedge clk);
    check("t6_arready", 32'(bus.s_arready), 1);
    tick();
    bus.s_arvalid = 1'b0;
    @(negedge clk);
    check("t6_r_req", 32'(state_o), 4);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_r_wait", 32'(state_o), 5);
    tick();
    @(negedge clk);
    check("t6_rst_state", 32'(state_o), 0);
    check("t6_rst_rvalid", 32'(bus.s_rvalid), 0);
    check("t6_rst_req", 32'(dm_req_o), 0);
    check("t6_rst_awready", 32'(bus.s_awready), 0);
    check("t6_rst_arready", 32'(bus.s_arready), 0);
    check("t6_rst_rdata", bus.s_rdata, 0);
    check("t6_rst_dm_addr", dm_addr_o, 0);
    check("t6_rst_dm_be", 32'(dm_be_o), 0);
    check("t6_rst_dm_wdata", dm_wdata_o, 0);
    tick();
    @(negedge clk);
    check("t6_rst_rvalid2", 32'(bus.s_rvalid), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_post_arready", 32'(bus.s_arready), 1);
    check("t6_post_rvalid", 32'(bus.s_rvalid), 0);
    tick();
    rd_value = 32'h7654_3210;
    push_req(1'b0, 32'h0000_080C, 4'h0, 32'h0);
    rd_q.push_back(32'h7654_3210);
    bus.s_rready = 1'b1;
    bus.s_araddr = 32'hFFFF_F80E; bus.s_arvalid = 1'b1;
    @(negedge clk);
    check("t6_arready2", 32'(bus.s_arready), 1);
    tick();
    bus.s_arvalid = 1'b0;
    wait_r(n);
    check("t6_r_latency", n, 2);
    tick();
    bus.s_rready = 1'b0;
    @(negedge clk);
    check("t6_idle", 32'(state_o), 0);

    check("end_req_q_empty", 32'(req_q.size()), 0);
    check("end_rd_q_empty", 32'(rd_q.size()), 0);
    check("end_b_q_empty", 32'(b_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
